// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - shared types and helpers for the xor checksum engine
package xor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/xor_checksum_if.sv
// rtl/xor_checksum_if.sv - word stream in, held checksum result out
interface xor_checksum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_sum;
    logic             m_parity;
    logic [CNT_W-1:0] m_count;
    logic             m_ovf;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_sum, m_parity, m_count, m_ovf
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_sum, m_parity, m_count, m_ovf
    );
endinterface

// File: rtl/xor_reduce.sv
// rtl/xor_reduce.sv - combinational reduction xor of a word
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);
    assign parity = ^data;
endmodule

// File: rtl/xor_checksum.sv
// rtl/xor_checksum.sv - streaming xor checksum with beat count and overflow flag
module xor_checksum
    import xor_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter int               MAX_WORDS = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    xor_checksum_if.slave  bus
);
    localparam int               CNT_W    = clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic             INIT_PAR = ^INIT;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ovf, ovf_nx;
    logic             vld, vld_nx;
    logic             load;

    logic [WIDTH-1:0] sum_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             ovf_upd;
    logic             par_upd;

    logic [WIDTH-1:0] sum_r;
    logic             par_r;
    logic [CNT_W-1:0] count_r;
    logic             ovf_r;

    assign sum_upd = acc ^ bus.s_data;
    assign cnt_upd = (cnt == MAX_CNT) ? cnt : cnt + 1'b1;
    assign ovf_upd = ovf | (cnt == MAX_CNT);

    xor_reduce #(.WIDTH(WIDTH)) u_parity (
        .data   (sum_upd),
        .parity (par_upd)
    );

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        vld_nx   = vld;
        load     = 1'b0;
        if (clr) begin
            state_nx = IDLE;
            acc_nx   = INIT;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
            vld_nx   = 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (bus.s_valid) begin
                        if (bus.s_last) begin
                            load     = 1'b1;
                            vld_nx   = 1'b1;
                            state_nx = HOLD;
                            acc_nx   = INIT;
                            cnt_nx   = '0;
                            ovf_nx   = 1'b0;
                        end else begin
                            acc_nx   = sum_upd;
                            cnt_nx   = cnt_upd;
                            ovf_nx   = ovf_upd;
                            state_nx = ACC;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        vld_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= INIT;
            cnt     <= '0;
            ovf     <= 1'b0;
            vld     <= 1'b0;
            sum_r   <= INIT;
            par_r   <= INIT_PAR;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
            vld   <= vld_nx;
            // Result data only changes on a last beat; clr and the handshake leave it alone.
            if (load) begin
                sum_r   <= sum_upd;
                par_r   <= par_upd;
                count_r <= cnt_upd;
                ovf_r   <= ovf_upd;
            end
        end
    end

    assign bus.s_ready  = (state != HOLD);
    assign bus.m_valid  = vld;
    assign bus.m_sum    = sum_r;
    assign bus.m_parity = par_r;
    assign bus.m_count  = count_r;
    assign bus.m_ovf    = ovf_r;
endmodule

// File: tb/tb_xor_checksum.sv
// tb/tb_xor_checksum.sv - directed and random checks on two xor_checksum configurations
module tb_xor_checksum;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xor_checksum_if #(.WIDTH(8), .CNT_W(3)) if_a ();
    xor_checksum_if #(.WIDTH(8), .CNT_W(8)) if_b ();

    assign if_a.s_valid = s_valid;
    assign if_a.s_data  = s_data;
    assign if_a.s_last  = s_last;
    assign if_a.m_ready = m_ready;
    assign if_b.s_valid = s_valid;
    assign if_b.s_data  = s_data;
    assign if_b.s_last  = s_last;
    assign if_b.m_ready = m_ready;

    xor_checksum #(.WIDTH(8), .INIT(8'h00), .MAX_WORDS(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (if_a)
    );

    xor_checksum #(.WIDTH(8), .INIT(8'hFF), .MAX_WORDS(255)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (if_b)
    );

    typedef struct {
        logic [7:0][7:0] data;
        int              len;
        logic [7:0]      sum_a;
        logic            par_a;
        logic [2:0]      cnt_a;
        logic            ovf_a;
        logic [7:0]      sum_b;
        logic            par_b;
        logic [7:0]      cnt_b;
        logic            ovf_b;
    } vec_t;

    vec_t vec [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        t = 0;
        while (!(if_a.s_ready && if_b.s_ready) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: s_ready stuck low for %0d cycles", t);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic check_result(input string name,
                                input logic [7:0] sa, input logic pa, input logic [2:0] ca, input logic oa,
                                input logic [7:0] sb, input logic pb, input logic [7:0] cb, input logic ob);
        chk({name, "_a_valid"},  if_a.m_valid,  1);
        chk({name, "_a_sum"},    if_a.m_sum,    sa);
        chk({name, "_a_parity"}, if_a.m_parity, pa);
        chk({name, "_a_count"},  if_a.m_count,  ca);
        chk({name, "_a_ovf"},    if_a.m_ovf,    oa);
        chk({name, "_b_valid"},  if_b.m_valid,  1);
        chk({name, "_b_sum"},    if_b.m_sum,    sb);
        chk({name, "_b_parity"}, if_b.m_parity, pb);
        chk({name, "_b_count"},  if_b.m_count,  cb);
        chk({name, "_b_ovf"},    if_b.m_ovf,    ob);
    endtask

    task automatic release_result(input string name);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({name, "_rel_valid"}, {if_a.m_valid, if_b.m_valid}, 2'b00);
        chk({name, "_rel_ready"}, {if_a.s_ready, if_b.s_ready}, 2'b11);
    endtask

    initial begin
        vec[0] = '{64'h0000_0000_0056_3412, 3, 8'h70, 1'b1, 3'd3, 1'b0, 8'h8F, 1'b1, 8'd3, 1'b0};
        vec[1] = '{64'h0000_0000_0000_00A5, 1, 8'hA5, 1'b0, 3'd1, 1'b0, 8'h5A, 1'b0, 8'd1, 1'b0};
        vec[2] = '{64'h0000_0101_0101_0101, 6, 8'h00, 1'b0, 3'd4, 1'b1, 8'hFF, 1'b0, 8'd6, 1'b0};
        vec[3] = '{64'h0000_0000_0000_0503, 2, 8'h06, 1'b0, 3'd2, 1'b0, 8'hF9, 1'b0, 8'd2, 1'b0};
        vec[4] = '{64'h0000_0001_1020_4080, 5, 8'hF1, 1'b1, 3'd4, 1'b1, 8'h0E, 1'b1, 8'd5, 1'b0};
        vec[5] = '{64'h0000_0000_8844_2211, 4, 8'hFF, 1'b0, 3'd4, 1'b0, 8'h00, 1'b0, 8'd4, 1'b0};

        rst_n   = 1'b0;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();

        chk("rst_m_valid", {if_a.m_valid, if_b.m_valid}, 2'b00);
        chk("rst_a_sum",   if_a.m_sum, 8'h00);
        chk("rst_b_sum",   if_b.m_sum, 8'hFF);
        chk("rst_b_par",   if_b.m_parity, 0);
        chk("rst_count",   {if_a.m_count, if_b.m_count}, 11'd0);
        chk("rst_ovf",     {if_a.m_ovf, if_b.m_ovf}, 2'b00);
        rst_n = 1'b1;
        tick();
        chk("rst_s_ready", {if_a.s_ready, if_b.s_ready}, 2'b11);

        // Partial frame wiped by an asynchronous reset mid-cycle.
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", {if_a.m_valid, if_b.m_valid}, 2'b00);
        chk("midrst_s_ready", {if_a.s_ready, if_b.s_ready}, 2'b11);
        chk("midrst_count",   {if_a.m_count, if_b.m_count}, 11'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vec[v].len; i++)
                send(vec[v].data[i], i == vec[v].len - 1);
            check_result($sformatf("vec%0d", v),
                         vec[v].sum_a, vec[v].par_a, vec[v].cnt_a, vec[v].ovf_a,
                         vec[v].sum_b, vec[v].par_b, vec[v].cnt_b, vec[v].ovf_b);
            release_result($sformatf("vec%0d", v));
        end

        // Backpressure: result held, beats offered during HOLD are ignored.
        send(8'h3C, 1'b1);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        s_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_a_sum",   if_a.m_sum, 8'h3C);
            chk("bp_b_sum",   if_b.m_sum, 8'hC3);
            chk("bp_s_ready", {if_a.s_ready, if_b.s_ready}, 2'b00);
            chk("bp_m_valid", {if_a.m_valid, if_b.m_valid}, 2'b11);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        release_result("bp");
        send(8'h01, 1'b1);
        check_result("bp_next", 8'h01, 1'b1, 3'd1, 1'b0, 8'hFE, 1'b1, 8'd1, 1'b0);
        release_result("bp_next");

        // clr drops the concurrent beat and the partial frame.
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'hFF;
        clr     = 1'b1;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        send(8'h11, 1'b1);
        check_result("clr", 8'h11, 1'b0, 3'd1, 1'b0, 8'hEE, 1'b0, 8'd1, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hold_valid", {if_a.m_valid, if_b.m_valid}, 2'b00);
        chk("clr_hold_ready", {if_a.s_ready, if_b.s_ready}, 2'b11);
        chk("clr_hold_sum",   if_a.m_sum, 8'h11);

        for (int f = 0; f < 1000; f++) begin
            int         len;
            logic [7:0] sa, sb, d;
            len = $urandom_range(1, 6);
            sa  = 8'h00;
            sb  = 8'hFF;
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                d  = 8'($urandom);
                sa = sa ^ d;
                sb = sb ^ d;
                send(d, i == len - 1);
            end
            check_result("rand", sa, ^sa, 3'((len > 4) ? 4 : len), len > 4,
                         sb, ^sb, 8'(len), 1'b0);
            repeat ($urandom_range(0, 3)) tick();
            release_result("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
